// File: rtl/timer_compare_pkg.sv
// -----------------------------------------------------------------------------
// timer_compare_pkg
// Shared constants and types for the compare-match timer:
//   - register addresses on the 2-bit MMIO select
//   - CTRL and STATUS bit positions
//   - the two-state arm/idle state type
// -----------------------------------------------------------------------------
package timer_compare_pkg;

   // Register map
   localparam logic [1:0] ADDR_CTRL    = 2'd0;
   localparam logic [1:0] ADDR_COMPARE = 2'd1;
   localparam logic [1:0] ADDR_PERIOD  = 2'd2;
   localparam logic [1:0] ADDR_STATUS  = 2'd3;

   // CTRL bit positions; only the low CTRL_W bits are stored
   localparam int CTRL_EN       = 0;
   localparam int CTRL_PERIODIC = 1;
   localparam int CTRL_IRQ_EN   = 2;
   localparam int CTRL_W        = 3;

   // STATUS bit positions
   localparam int STAT_PENDING = 0;
   localparam int STAT_ARMED   = 1;
   localparam int STAT_OVERRUN = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      ARMED = 1'b1
   } state_t;

endpackage : timer_compare_pkg

// File: rtl/timer_reached.sv
// -----------------------------------------------------------------------------
// timer_reached
// Combinational wrap-safe "target reached" test. The target counts as reached
// when it lies at most 2^(WIDTH-1)-1 counts behind the count, i.e. when the
// modular difference (count - target) has its MSB clear.
// Ports:
//   i_count   current free-running count
//   i_target  programmed compare value
//   o_reached 1 when the target has been reached
// -----------------------------------------------------------------------------
module timer_reached #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_count,
   input  logic [WIDTH-1:0] i_target,
   output logic             o_reached
);

   logic [WIDTH-1:0] w_diff;

   // Modular subtraction: wraps naturally at 2^WIDTH
   assign w_diff    = i_count - i_target;
   assign o_reached = ~w_diff[WIDTH-1];

endmodule : timer_reached

// File: rtl/timer_compare.sv
// -----------------------------------------------------------------------------
// timer_compare
// Compare-match interrupt generator watching a free-running cycle counter.
// One-shot and periodic modes; 4-register MMIO port (CTRL, COMPARE, PERIOD,
// STATUS) with registered read data.
// Ports:
//   clk       system clock
//   reset     asynchronous, active-high reset
//   count_in  free-running count (+1 per cycle max, wraps)
//   wr_en     register write strobe
//   rd_en     register read strobe (rd_data loads on this edge)
//   addr      register select
//   wr_data   write data
//   rd_data   registered read data, holds when rd_en = 0
//   irq_ack   pulse that clears the pending flag
//   irq       registered level interrupt request
// -----------------------------------------------------------------------------
module timer_compare
   import timer_compare_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] count_in,
   input  logic             wr_en,
   input  logic             rd_en,
   input  logic [1:0]       addr,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   input  logic             irq_ack,
   output logic             irq
);

   // Architectural state
   state_t             r_state;
   logic [CTRL_W-1:0]  r_ctrl;
   logic [WIDTH-1:0]   r_compare;
   logic [WIDTH-1:0]   r_period;
   logic               r_pending;
   logic               r_overrun;
   logic               r_irq;
   logic [WIDTH-1:0]   r_rd_data;

   // Decode and event wires
   logic               w_reached;
   logic               w_ctrl_wr;
   logic               w_compare_wr;
   logic               w_period_wr;
   logic               w_status_wr;
   logic               w_disarm;
   logic               w_fire;
   logic               w_reload;
   logic               w_pend_clr;
   logic               w_ovr_set;

   // Next-state wires
   state_t             w_state_next;
   logic [CTRL_W-1:0]  w_ctrl_next;
   logic [WIDTH-1:0]   w_compare_next;
   logic               w_pending_next;
   logic               w_overrun_next;
   logic [WIDTH-1:0]   w_status;
   logic [WIDTH-1:0]   w_rd_sel;

   timer_reached #(
      .WIDTH (WIDTH)
   ) u_reached (
      .i_count   (count_in),
      .i_target  (r_compare),
      .o_reached (w_reached)
   );

   assign w_ctrl_wr    = wr_en && (addr == ADDR_CTRL);
   assign w_compare_wr = wr_en && (addr == ADDR_COMPARE);
   assign w_period_wr  = wr_en && (addr == ADDR_PERIOD);
   assign w_status_wr  = wr_en && (addr == ADDR_STATUS);

   // A CTRL write clearing enable suppresses a fire in the same cycle
   assign w_disarm   = w_ctrl_wr && !wr_data[CTRL_EN];
   assign w_fire     = (r_state == ARMED) && w_reached && !w_disarm;
   // Periodic with a zero period would refire forever; treat it as one-shot
   assign w_reload   = r_ctrl[CTRL_PERIODIC] && (r_period != '0);
   assign w_pend_clr = irq_ack || (w_status_wr && wr_data[STAT_PENDING]);
   // Overrun only when an earlier fire is still unserviced this cycle
   assign w_ovr_set  = w_fire && r_pending && !w_pend_clr;

   always_comb begin
      w_state_next   = r_state;
      w_ctrl_next    = r_ctrl;
      w_compare_next = r_compare;
      w_pending_next = r_pending;
      w_overrun_next = r_overrun;

      if (w_fire) begin
         if (w_reload) begin
            w_compare_next = r_compare + r_period;   // wraps silently
         end else begin
            w_ctrl_next[CTRL_EN] = 1'b0;
            w_state_next         = IDLE;
         end
      end

      // CPU writes take priority over the automatic updates above
      if (w_ctrl_wr) begin
         w_ctrl_next  = wr_data[CTRL_W-1:0];
         w_state_next = wr_data[CTRL_EN] ? ARMED : IDLE;
      end
      if (w_compare_wr) begin
         w_compare_next = wr_data;
      end

      // A fire beats a clear of pending in the same cycle
      if (w_pend_clr) begin
         w_pending_next = 1'b0;
      end
      if (w_fire) begin
         w_pending_next = 1'b1;
      end

      if (w_status_wr && wr_data[STAT_OVERRUN]) begin
         w_overrun_next = 1'b0;
      end
      if (w_ovr_set) begin
         w_overrun_next = 1'b1;
      end
   end

   // Read mux sees the pre-edge register values, so a same-cycle write
   // to the addressed register returns the old contents.
   always_comb begin
      w_status               = '0;
      w_status[STAT_PENDING] = r_pending;
      w_status[STAT_ARMED]   = (r_state == ARMED);
      w_status[STAT_OVERRUN] = r_overrun;

      w_rd_sel = '0;
      case (addr)
         ADDR_CTRL:    w_rd_sel[CTRL_W-1:0] = r_ctrl;
         ADDR_COMPARE: w_rd_sel = r_compare;
         ADDR_PERIOD:  w_rd_sel = r_period;
         ADDR_STATUS:  w_rd_sel = w_status;
         default:      w_rd_sel = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_ctrl    <= '0;
         r_compare <= '0;
         r_period  <= '0;
         r_pending <= 1'b0;
         r_overrun <= 1'b0;
         r_irq     <= 1'b0;
         r_rd_data <= '0;
      end else begin
         r_state   <= w_state_next;
         r_ctrl    <= w_ctrl_next;
         r_compare <= w_compare_next;
         if (w_period_wr) begin
            r_period <= wr_data;
         end
         r_pending <= w_pending_next;
         r_overrun <= w_overrun_next;
         // Built from next values so irq moves on the same edge as pending
         r_irq     <= w_pending_next & w_ctrl_next[CTRL_IRQ_EN];
         if (rd_en) begin
            r_rd_data <= w_rd_sel;
         end
      end
   end

   assign rd_data = r_rd_data;
   assign irq     = r_irq;

endmodule : timer_compare
